mul_div_unit: RTL and testbench

- Iterative multiply/divide unit beside the single-cycle ALU in the EX stage.
- Executes mult, multu, div and divu over multiple cycles using a start/busy/done handshake.
- Holds results in architectural HI/LO registers.
- The control unit stalls the PC while busy is high, then reads HI/LO for mfhi/mflo. Direct HI/LO writes (mthi/mtlo) are also supported.

---
 rtl/mul_div_unit.sv | 105 ++++++++++
 tb/tb_mul_div_unit.sv | 113 +++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-step multiply/divide unit with architectural HI/LO registers
//   CLK, RST_n        : clock, asynchronous active-low reset
//   start, MDOp, A, B : request (00 mult, 01 multu, 10 div, 11 divu) and operands, sampled in IDLE
//   hi_we, lo_we, wdata : mthi/mtlo writes, honoured in IDLE only
//   busy, done, div_zero : handshake; done and div_zero pulse together for one cycle
//   HI, LO            : product high/low words, or remainder/quotient
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             start,
  input  logic [1:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t state;
  logic [1:0] op;
  logic sa, sb;
  logic [WIDTH-1:0] m, hacc, lq;
  logic [CNT_W-1:0] cnt;
  logic a_neg, b_neg, dz;
  logic [WIDTH-1:0] abs_a, abs_b, q_fix, r_fix;
  logic [WIDTH:0] msum, rsh, diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  // lq holds the multiplier / dividend and shifts out as the product low word / quotient
  // shifts in; hacc is the product high word / partial remainder; m is multiplicand / divisor.
  always_comb begin
    a_neg = ~MDOp[0] & A[WIDTH-1];
    b_neg = ~MDOp[0] & B[WIDTH-1];
    abs_a = a_neg ? -A : A;
    abs_b = b_neg ? -B : B;
    msum = {1'b0, hacc} + (lq[0] ? {1'b0, m} : '0);
    rsh = {hacc, lq[WIDTH-1]};
    diff = rsh - {1'b0, m};
    prod = {hacc, lq};
    prod_fix = (sa ^ sb) ? -prod : prod;
    q_fix = (sa ^ sb) ? -lq : lq;
    r_fix = sa ? -hacc : hacc;
    dz = (m == '0);
  end
  // With a zero divisor every trial subtract succeeds trivially, so the remainder ends up as
  // the dividend magnitude and the sign fix restores the original A for HI; only LO is forced.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= IDLE;
      op <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      m <= '0;
      hacc <= '0;
      lq <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      div_zero <= 1'b0;
      HI <= '0;
      LO <= '0;
    end else begin
      done <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) HI <= wdata;
          if (lo_we) LO <= wdata;
          if (start) begin
            op <= MDOp;
            sa <= a_neg;
            sb <= b_neg;
            m <= MDOp[1] ? abs_b : abs_a;
            lq <= MDOp[1] ? abs_a : abs_b;
            hacc <= '0;
            cnt <= '0;
            busy <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          hacc <= op[1] ? (diff[WIDTH] ? rsh[WIDTH-1:0] : diff[WIDTH-1:0]) : msum[WIDTH:1];
          lq <= op[1] ? {lq[WIDTH-2:0], ~diff[WIDTH]} : {msum[0], lq[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FINISH;
        end
        default: begin
          HI <= op[1] ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
          LO <= op[1] ? (dz ? '1 : q_fix) : prod_fix[WIDTH-1:0];
          div_zero <= op[1] & dz;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [1:0] mdop = '0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic hi_we = 1'b0, lo_we = 1'b0;
  logic busy, done, div_zero;
  logic [31:0] hi, lo;
  int total = 0;
  int bad = 0;
  int bcnt;
  bit dzs;
  mul_div_unit dut (
    .CLK(clk), .RST_n(rst_n), .start(start), .MDOp(mdop), .A(a), .B(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .HI(hi), .LO(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Issue one operation, scramble the operands after acceptance, count busy cycles,
  // capture div_zero with done, then confirm done drops after one cycle.
  task automatic run(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                     output int bc, output bit dz);
    @(negedge clk);
    start = 1'b1; mdop = op; a = x; b = y;
    @(negedge clk);
    start = 1'b0; mdop = 2'(~op); a = $urandom; b = $urandom;
    bc = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (busy) bc++;
      @(negedge clk);
    end
    chk("done_seen", {63'd0, done}, 64'd1);
    dz = div_zero;
    @(negedge clk);
    chk("done_pulse", {63'd0, done}, 64'd0);
  endtask
  initial begin
    #12;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_flags", {61'd0, busy, done, div_zero}, 64'd0);
    rst_n = 1'b1;
    run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, bcnt, dzs);
    chk("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    chk("busy_len", 64'(bcnt), 64'd33);
    run(2'b00, 32'hFFFFFFFD, 32'd5, bcnt, dzs);
    chk("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    run(2'b00, 32'h80000000, 32'h80000000, bcnt, dzs);
    chk("mult_min", {hi, lo}, 64'h40000000_00000000);
    run(2'b10, 32'hFFFFFFF9, 32'd2, bcnt, dzs);
    chk("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    chk("div_nz", 64'(dzs), 64'd0);
    run(2'b11, 32'd7, 32'd2, bcnt, dzs);
    chk("divu", {hi, lo}, 64'h00000001_00000003);
    run(2'b10, 32'h80000000, 32'hFFFFFFFF, bcnt, dzs);
    chk("div_ovf", {hi, lo}, 64'h00000000_80000000);
    run(2'b11, 32'd7, 32'd0, bcnt, dzs);
    chk("divu_zero", {hi, lo}, 64'h00000007_FFFFFFFF);
    chk("divu_zero_flag", 64'(dzs), 64'd1);
    chk("divu_zero_lat", 64'(bcnt), 64'd33);
    run(2'b10, 32'hFFFFFFF9, 32'd0, bcnt, dzs);
    chk("div_zero_hi", {hi, lo}, 64'hFFFFFFF9_FFFFFFFF);
    chk("div_zero_flag", 64'(dzs), 64'd1);
    // requests while busy must be ignored
    @(negedge clk);
    start = 1'b1; mdop = 2'b01; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; mdop = 2'b00; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    chk("busy_hold", {hi, lo}, 64'hFFFFFFF9_FFFFFFFF);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    chk("busy_ign", {hi, lo}, 64'h00000000_0000000C);
    @(negedge clk);
    chk("idle_after", {62'd0, busy, done}, 64'd0);
    lo_we = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo", {hi, lo}, 64'h00000000_0000ABCD);
    hi_we = 1'b1; wdata = 32'h5555;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", {hi, lo}, 64'h00005555_0000ABCD);
    // asynchronous reset mid-operation
    start = 1'b1; mdop = 2'b00; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hilo", {hi, lo}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(2'b11, 32'd100, 32'd7, bcnt, dzs);
    chk("divu_after_rst", {hi, lo}, 64'h00000002_0000000E);
    chk("lat_after_rst", 64'(bcnt), 64'd33);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
